// File: rtl/perm_cu_mr.sv
// rtl/perm_cu_mr.sv - multi-round permutation control unit (read/load/write per lane, rounds, finish)
// Optional abort input enabled by defining PERM_CU_ABORT_EN.
module perm_cu_mr #(
  parameter int LANES  = 25,
  parameter int ROUNDS = 24,
  parameter int LW     = $clog2(LANES),
  parameter int RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          wr_stall,
  output logic          reset_reg,
  output logic          read_input,
  output logic          load_reg,
  output logic          write_output,
  output logic          round_done,
  output logic          busy,
  output logic          ready,
  output logic [LW-1:0] lane_idx,
  output logic [RW-1:0] round_idx
`ifdef PERM_CU_ABORT_EN
  ,
  input  logic          abort
`endif
);

  localparam logic [LW-1:0] LANE_LAST  = LW'(LANES - 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_READ   = 3'd2,
    S_LOAD   = 3'd3,
    S_WRITE  = 3'd4,
    S_ROUND  = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  state_t state, state_next;
  logic   abort_hit;

`ifdef PERM_CU_ABORT_EN
  assign abort_hit = abort && (state != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_INIT;
      S_INIT:   if (!start) state_next = S_READ;
      S_READ:   state_next = S_LOAD;
      S_LOAD:   state_next = S_WRITE;
      S_WRITE: begin
        if (!wr_stall) begin
          if (lane_idx < LANE_LAST)        state_next = S_READ;
          else if (round_idx < ROUND_LAST) state_next = S_ROUND;
          else                             state_next = S_FINISH;
        end
      end
      S_ROUND:  state_next = S_READ;
      S_FINISH: if (start) state_next = S_INIT;
      default:  state_next = S_IDLE;
    endcase
    if (abort_hit) state_next = S_IDLE;
  end

  // Counters are already zero on the first INIT cycle; the final lane is not wrapped on exit to FINISH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_idx  <= '0;
      round_idx <= '0;
    end else if (abort_hit || state_next == S_INIT || state == S_INIT) begin
      lane_idx  <= '0;
      round_idx <= '0;
    end else if (state == S_WRITE && !wr_stall && state_next != S_FINISH) begin
      lane_idx <= (lane_idx == LANE_LAST) ? '0 : lane_idx + LW'(1);
      if (state_next == S_ROUND) round_idx <= round_idx + RW'(1);
    end
  end

  always_comb begin
    reset_reg    = 1'b0;
    read_input   = 1'b0;
    load_reg     = 1'b0;
    write_output = 1'b0;
    round_done   = 1'b0;
    busy         = 1'b0;
    ready        = 1'b0;
    case (state)
      S_INIT:   reset_reg = 1'b1;
      S_READ:   begin read_input   = 1'b1; busy = 1'b1; end
      S_LOAD:   begin load_reg     = 1'b1; busy = 1'b1; end
      S_WRITE:  begin write_output = 1'b1; busy = 1'b1; end
      S_ROUND:  begin round_done   = 1'b1; busy = 1'b1; end
      S_FINISH: ready = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_perm_cu_mr.sv
// tb/tb_perm_cu_mr.sv - directed bench for perm_cu_mr (LANES=3/ROUNDS=2 and LANES=2/ROUNDS=1 instances)
module tb_perm_cu_mr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic wr_stall = 1'b0;
  logic sel = 1'b0;
`ifdef PERM_CU_ABORT_EN
  logic abort = 1'b0;
`endif

  logic       start0, start1, stall0, stall1;
  logic       rr0, rd0, ld0, wr0, rn0, bz0, rdy0;
  logic [1:0] lane0;
  logic [0:0] round0;
  logic       rr1, rd1, ld1, wr1, rn1, bz1, rdy1;
  logic [0:0] lane1;
  logic [0:0] round1;

  assign start0 = sel ? 1'b0 : start;
  assign start1 = sel ? start : 1'b0;
  assign stall0 = sel ? 1'b0 : wr_stall;
  assign stall1 = sel ? wr_stall : 1'b0;

  perm_cu_mr #(.LANES(3), .ROUNDS(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .wr_stall(stall0),
    .reset_reg(rr0), .read_input(rd0), .load_reg(ld0), .write_output(wr0),
    .round_done(rn0), .busy(bz0), .ready(rdy0), .lane_idx(lane0), .round_idx(round0)
`ifdef PERM_CU_ABORT_EN
    , .abort(abort)
`endif
  );

  perm_cu_mr #(.LANES(2), .ROUNDS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .wr_stall(stall1),
    .reset_reg(rr1), .read_input(rd1), .load_reg(ld1), .write_output(wr1),
    .round_done(rn1), .busy(bz1), .ready(rdy1), .lane_idx(lane1), .round_idx(round1)
`ifdef PERM_CU_ABORT_EN
    , .abort(1'b0)
`endif
  );

  always #5 clk = ~clk;

  logic o_rr, o_rd, o_ld, o_wr, o_rn, o_bz, o_rdy;
  int   o_lane, o_round;
  always_comb begin
    o_rr    = sel ? rr1  : rr0;
    o_rd    = sel ? rd1  : rd0;
    o_ld    = sel ? ld1  : ld0;
    o_wr    = sel ? wr1  : wr0;
    o_rn    = sel ? rn1  : rn0;
    o_bz    = sel ? bz1  : bz0;
    o_rdy   = sel ? rdy1 : rdy0;
    o_lane  = sel ? int'(lane1)  : int'(lane0);
    o_round = sel ? int'(round1) : int'(round0);
  end

  int n_checks = 0;
  int n_pass = 0;
  int cyc, n_rd, n_wr, n_rnd, seq, max_run;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two INIT cycles with start high, then release; returns in the first READ cycle.
  task automatic launch(input string tag);
    start = 1'b1;
    step();
    check({tag, "_init_reset_reg"}, o_rr, 1);
    check({tag, "_init_lane"}, o_lane, 0);
    check({tag, "_init_round"}, o_round, 0);
    check({tag, "_init_ready"}, o_rdy, 0);
    step();
    start = 1'b0;
    step();
    check({tag, "_first_read"}, o_rd, 1);
  endtask

  task automatic run(input int bound, input int stall_on, input int stall_len, input bit poke_start);
    int  wr_entry = 0;
    int  stall_cnt = 0;
    int  run_len = 0;
    bit  prev_wr = 1'b0;
    cyc = 0; n_rd = 0; n_wr = 0; n_rnd = 0; seq = 0; max_run = 0;
    while (!o_rdy && cyc < bound) begin
      if (o_rd) begin n_rd++; seq = seq * 10 + o_lane; end
      if (o_wr) begin
        n_wr++;
        run_len++;
        if (!prev_wr) wr_entry++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (o_rn) n_rnd++;
      prev_wr = o_wr;
      if (o_wr && wr_entry == stall_on && stall_cnt < stall_len) begin
        wr_stall = 1'b1;
        stall_cnt++;
        check("stall_lane", o_lane, 1);
      end else begin
        wr_stall = 1'b0;
      end
      if (poke_start) start = (cyc >= 4 && cyc < 6);
      step();
      cyc++;
    end
    wr_stall = 1'b0;
    check("ready_seen", o_rdy, 1);
  endtask

  initial begin
    int k;
    step();
    step();
    check("rst_busy", o_bz, 0);
    check("rst_reset_reg", o_rr, 0);
    check("rst_ready", o_rdy, 0);
    check("rst_lane", o_lane, 0);
    check("rst_round", o_round, 0);
    rst_n = 1'b1;
    repeat (3) step();
    check("idle_hold_reset_reg", o_rr, 0);
    check("idle_hold_busy", o_bz, 0);

    launch("a");
    run(100, 0, 0, 1'b0);
    check("a_cycles", cyc, 19);
    check("a_reads", n_rd, 6);
    check("a_writes", n_wr, 6);
    check("a_round_done", n_rnd, 1);
    check("a_lane_seq", seq, 12012);
    check("a_fin_lane", o_lane, 2);
    check("a_fin_round", o_round, 1);
    check("a_fin_busy", o_bz, 0);

    launch("b");
    run(100, 0, 0, 1'b1);
    check("b_cycles", cyc, 19);
    check("b_reads", n_rd, 6);
    check("b_writes", n_wr, 6);
    check("b_round_done", n_rnd, 1);
    check("b_lane_seq", seq, 12012);

    launch("c");
    run(100, 2, 4, 1'b0);
    check("c_cycles", cyc, 23);
    check("c_write_cycles", n_wr, 10);
    check("c_write_run", max_run, 5);
    check("c_reads", n_rd, 6);
    check("c_lane_seq", seq, 12012);

    launch("d");
    k = 0;
    while (!(o_ld && o_round == 1) && k < 100) begin step(); k++; end
    check("d_reach_load_r1", o_ld, 1);
    rst_n = 1'b0;
    #1;
    check("d_async_load", o_ld, 0);
    check("d_async_busy", o_bz, 0);
    check("d_async_lane", o_lane, 0);
    check("d_async_round", o_round, 0);
    step();
    rst_n = 1'b1;
    step();
    check("d_idle_busy", o_bz, 0);
    launch("d2");
    run(100, 0, 0, 1'b0);
    check("d2_cycles", cyc, 19);
    check("d2_round_done", n_rnd, 1);

    sel = 1'b1;
    #1;
    launch("e");
    run(100, 0, 0, 1'b0);
    check("e_cycles", cyc, 6);
    check("e_round_done", n_rnd, 0);
    check("e_reads", n_rd, 2);
    check("e_lane_seq", seq, 1);
    check("e_fin_lane", o_lane, 1);

`ifdef PERM_CU_ABORT_EN
    sel = 1'b0;
    #1;
    launch("f");
    k = 0;
    while (!o_wr && k < 20) begin step(); k++; end
    check("f_reach_write", o_wr, 1);
    wr_stall = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    wr_stall = 1'b0;
    check("f_abort_busy", o_bz, 0);
    check("f_abort_write", o_wr, 0);
    check("f_abort_lane", o_lane, 0);
    check("f_abort_round", o_round, 0);
    k = 0;
    repeat (5) begin
      if (o_rdy) k++;
      step();
    end
    check("f_no_ready", k, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/perm_cu_mr.md
PERM_CU_MR -- requirements
Module: perm_cu_mr

Interface
REQ-001 The parameter list SHALL be as below, one per line: name, default, meaning.
- LANES, 25, data words processed per round; legal range 2..256.
- ROUNDS, 24, rounds per permutation; legal range 1..256.
- LW, $clog2(LANES), width of lane_idx.
- RW, $clog2(ROUNDS) or 1 if ROUNDS=1, width of round_idx.
REQ-002 The port list SHALL be as below, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on posedge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, level request; a falling edge seen in INIT launches the run.
- wr_stall, in, 1, downstream not ready; holds WRITE.
- reset_reg, out, 1, clear datapath registers.
- read_input, out, 1, fetch word lane_idx of the current round.
- load_reg, out, 1, capture the permuted word.
- write_output, out, 1, present the word to downstream.
- round_done, out, 1, one-cycle pulse between rounds.
- busy, out, 1, high in READ, LOAD, WRITE and ROUND.
- ready, out, 1, permutation complete.
- lane_idx, out, LW, current lane counter.
- round_idx, out, RW, current round counter.
- abort, in, 1, present only with PERM_CU_ABORT_EN.

Function
REQ-003 The FSM SHALL have seven states: IDLE, INIT, READ, LOAD, WRITE, ROUND and FINISH; the state register is clocked and all outputs are decoded from the present state only.
REQ-004 Output decode SHALL be:
- INIT: reset_reg=1.
- READ: read_input=1.
- LOAD: load_reg=1.
- WRITE: write_output=1.
- ROUND: round_done=1.
- FINISH: ready=1.
- IDLE: all control outputs 0.
- In every state, all outputs not listed for that state SHALL be 0.
REQ-005 Transitions SHALL be:
- IDLE->INIT if start=1, else stay in IDLE.
- INIT stays in INIT while start=1; INIT->READ when start=0.
- READ->LOAD, unconditional.
- LOAD->WRITE, unconditional.
- WRITE stays in WRITE while wr_stall=1.
- WRITE->READ if lane_idx<LANES-1.
- WRITE->ROUND if lane_idx=LANES-1 and round_idx<ROUNDS-1.
- WRITE->FINISH if lane_idx=LANES-1 and round_idx=ROUNDS-1.
- ROUND->READ, unconditional.
- FINISH->INIT if start=1, else stay in FINISH.
- Illegal state codes go to IDLE.
REQ-006 Both counters SHALL be cleared in INIT.
REQ-007 lane_idx SHALL increment only on a WRITE cycle with wr_stall=0, and SHALL wrap to 0 after LANES-1.
REQ-008 round_idx SHALL increment on the WRITE exit into ROUND; in FINISH both counters SHALL hold their final values (LANES-1 and ROUNDS-1).
REQ-009 With wr_stall=0 throughout, the run from the first READ to FINISH entry SHALL take ROUNDS*3*LANES+(ROUNDS-1) cycles.
REQ-010 A stall SHALL extend WRITE by exactly its length in cycles, with no counter change and no dropped lane.
REQ-011 With ROUNDS=1, ROUND SHALL never be entered.
REQ-012 start changes during the run states (READ, LOAD, WRITE, ROUND) SHALL be ignored.

Reset
REQ-013 rst_n=0 SHALL force IDLE, lane_idx=0, round_idx=0 and all control outputs 0 immediately, independent of clk, including mid-run.
REQ-014 After rst_n rises, the block SHALL leave IDLE only on a sampled start=1.

Configuration
REQ-015 With PERM_CU_ABORT_EN defined:
- The port abort SHALL exist.
- abort=1 sampled in any state other than IDLE SHALL force IDLE at the next edge and clear both counters.
- abort SHALL have priority over start and wr_stall.
REQ-016 Without PERM_CU_ABORT_EN:
- The abort port SHALL be absent.
- Only rst_n can terminate a run.

Verification
REQ-017 LANES=3, ROUNDS=2, start high for 2 cycles then low, wr_stall=0 -> ready rises 19 cycles after the first READ, with exactly one round_done pulse, six read_input and six write_output pulses, and lane_idx following 0,1,2,0,1,2.
REQ-018 Same configuration, wr_stall=1 for 4 cycles during the second WRITE -> write_output is high for 5 consecutive cycles, lane_idx stays 1 during the stall, and ready is delayed by 4 cycles (23 total).
REQ-019 rst_n pulsed low during LOAD of round 1 -> outputs go to 0 and the counters to 0 within the same cycle; a new start completes a normal 19-cycle run.
REQ-020 In FINISH, raise start -> INIT with reset_reg=1, the counters cleared and ready=0; the second run is identical to the first.
REQ-021 ROUNDS=1, LANES=2 -> no round_done pulse, and ready after 6 cycles.
REQ-022 PERM_CU_ABORT_EN defined, abort=1 in WRITE with wr_stall=1 -> IDLE at the next edge, counters at 0, and ready never asserted.
